shift_unit: RTL

Parametrised multi-cycle shift/rotate engine for the CPU datapath; successor to the single-cycle shifter path inside the ALU. Takes the Y-register operand and a shift amount from the bus, performs SHR, SHRA, SHL, ROR or ROL at STEP bits per clock, and presents the result for loading into Z. A start/busy/done handshake lets the control unit sequence it, trading latency for area when STEP is small.

---
 rtl/shift_pkg.sv | 33 +++
 rtl/shift_step.sv | 35 +++
 rtl/shift_unit.sv | 102 ++++++++++
 3 files changed

// File: rtl/shift_pkg.sv
// Shared definitions for the multi-cycle shift/rotate engine: op codes,
// FSM states and the effective-count rule applied when an operation starts.
package shift_pkg;

  localparam logic [4:0] OP_SHR  = 5'b00111;
  localparam logic [4:0] OP_SHRA = 5'b01000;
  localparam logic [4:0] OP_SHL  = 5'b01001;
  localparam logic [4:0] OP_ROR  = 5'b01010;
  localparam logic [4:0] OP_ROL  = 5'b01011;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  function automatic logic is_legal(input logic [4:0] op);
    return (op == OP_SHR) || (op == OP_SHRA) || (op == OP_SHL) ||
           (op == OP_ROR) || (op == OP_ROL);
  endfunction

  // amt_big: amount >= width; amt_low: amount mod width (width is a power of 2)
  function automatic int unsigned eff_count(input logic [4:0]  op,
                                            input logic        amt_big,
                                            input int unsigned amt_low,
                                            input int unsigned width);
    if (!is_legal(op)) return 0;
    if ((op == OP_ROR) || (op == OP_ROL)) return amt_low;
    if (amt_big) return width;
    return amt_low;
  endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational single-step shifter: moves a WIDTH value by k (0..STEP) bits
// according to op, with zero fill, sign fill or wrap-around.
module shift_step
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned STEP  = 1,
  localparam int unsigned KW   = $clog2(STEP) + 1
) (
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] value,
  input  logic [KW-1:0]    k,
  output logic [WIDTH-1:0] out
);

  logic [2*WIDTH-1:0] dbl;
  logic [2*WIDTH-1:0] dbl_r;
  logic [2*WIDTH-1:0] dbl_l;

  // Rotates shift a doubled copy so wrapped bits come in from the twin half.
  always_comb begin
    dbl   = {value, value};
    dbl_r = dbl >> k;
    dbl_l = dbl << k;
    case (op)
      OP_SHR:  out = value >> k;
      OP_SHRA: out = $signed(value) >>> k;
      OP_SHL:  out = value << k;
      OP_ROR:  out = dbl_r[WIDTH-1:0];
      OP_ROL:  out = dbl_l[2*WIDTH-1:WIDTH];
      default: out = value;
    endcase
  end

endmodule

// File: rtl/shift_unit.sv
// Multi-cycle shift/rotate engine with start/busy/done handshake; shifts up
// to STEP bits per clock and holds the last completed result.
module shift_unit
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned STEP  = 1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [4:0]       op_code,
  input  logic [WIDTH-1:0] operand,
  input  logic [WIDTH-1:0] amount,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] result
);

  localparam int unsigned LW = $clog2(WIDTH);
  localparam int unsigned CW = LW + 1;
  localparam int unsigned KW = $clog2(STEP) + 1;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] acc;
  logic [CW-1:0]    cnt;
  logic [4:0]       op;
  logic             err_q;

  logic             amt_big;
  logic [CW-1:0]    n_start;
  logic [KW-1:0]    k;
  logic [CW-1:0]    cnt_rem;
  logic [WIDTH-1:0] step_out;

  always_comb begin
    amt_big = |amount[WIDTH-1:LW];
    n_start = CW'(eff_count(op_code, amt_big, 32'(amount[LW-1:0]), WIDTH));
  end

  always_comb begin
    k       = (cnt >= CW'(STEP)) ? KW'(STEP) : cnt[KW-1:0];
    cnt_rem = cnt - CW'(k);
  end

  shift_step #(
    .WIDTH(WIDTH),
    .STEP (STEP)
  ) u_step (
    .op   (op),
    .value(acc),
    .k    (k),
    .out  (step_out)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (n_start != '0) ? SHIFT : DONE;
      SHIFT:   if (cnt_rem == '0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) state <= IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      acc    <= '0;
      cnt    <= '0;
      op     <= '0;
      err_q  <= 1'b0;
      result <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          acc   <= operand;
          cnt   <= n_start;
          op    <= op_code;
          err_q <= !is_legal(op_code);
        end
        SHIFT: begin
          acc <= step_out;
          cnt <= cnt_rem;
        end
        DONE:    result <= acc;
        default: ;
      endcase
    end
  end

  assign busy = (state == SHIFT);
  assign done = (state == DONE);
  assign err  = done & err_q;

endmodule
